// File: rtl/delay_pkg.sv
// Shared constants and helpers for the variable delay line.
// A stage record is {valid, data[WIDTH-1:0]}, with the valid flag in the MSB.
package delay_pkg;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultMaxDelay = 16;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Bit position of the valid flag within a stage record.
  function automatic int unsigned valid_bit(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Clamps the requested delay into 1..MAX_DELAY and selects the matching
// {valid, data} stage. The index never leaves the stage array.
module delay_tap_mux
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MAX_DELAY = DefaultMaxDelay,
  parameter int unsigned DELAY_W   = clog2(MAX_DELAY + 1)
) (
  input  logic [MAX_DELAY-1:0][WIDTH:0] stages_i,
  input  logic [DELAY_W-1:0]            delay_sel_i,
  output logic [DELAY_W-1:0]            eff_delay_o,
  output logic                          clamped_o,
  output logic [WIDTH:0]                tap_o
);

  always_comb begin
    eff_delay_o = delay_sel_i;
    clamped_o   = 1'b0;
    if (delay_sel_i == '0) begin
      eff_delay_o = DELAY_W'(1);
      clamped_o   = 1'b1;
    end else if (delay_sel_i > DELAY_W'(MAX_DELAY)) begin
      eff_delay_o = DELAY_W'(MAX_DELAY);
      clamped_o   = 1'b1;
    end
  end

  // Compare-based selection keeps the mux width-exact for any DELAY_W.
  always_comb begin
    tap_o = '0;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (eff_delay_o == DELAY_W'(k + 1)) begin
        tap_o = stages_i[k];
      end
    end
  end

endmodule

// File: rtl/delay_line_var.sv
// Variable-depth delay for a data word plus valid flag, with stall, flush and
// a primed indicator that tracks how many post-event samples fill the tap.
module delay_line_var
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MAX_DELAY = DefaultMaxDelay,
  parameter int unsigned DELAY_W   = clog2(MAX_DELAY + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic [DELAY_W-1:0] delay_sel_i,
  input  logic [WIDTH-1:0]   in_data_i,
  input  logic               in_valid_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic               out_valid_o,
  output logic               primed_o,
  output logic               sel_clamped_o
);

  localparam int unsigned VBit = valid_bit(WIDTH);

  logic [MAX_DELAY-1:0][WIDTH:0] stage_q, stage_d;
  logic [DELAY_W-1:0]            cnt_q, cnt_d;
  logic [DELAY_W-1:0]            prev_delay_q;
  logic [DELAY_W-1:0]            eff_delay;
  logic                          clamped_q;
  logic                          clamped_now;
  logic                          delay_changed;
  logic [WIDTH:0]                tap;

  delay_tap_mux #(
    .WIDTH     (WIDTH),
    .MAX_DELAY (MAX_DELAY),
    .DELAY_W   (DELAY_W)
  ) u_tap_mux (
    .stages_i    (stage_q),
    .delay_sel_i (delay_sel_i),
    .eff_delay_o (eff_delay),
    .clamped_o   (clamped_now),
    .tap_o       (tap)
  );

  assign delay_changed = (eff_delay != prev_delay_q);

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = {in_valid_i, in_data_i};
      for (int unsigned k = 1; k < MAX_DELAY; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
    // Flush drops every valid, including the word presented on this edge.
    if (flush_i) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++) begin
        stage_d[k][VBit] = 1'b0;
      end
    end
  end

  // Counter = number of enabled samples taken since the last flush/delay change.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (delay_changed) begin
      cnt_d = en_i ? DELAY_W'(1) : '0;
    end else if (en_i && (cnt_q < DELAY_W'(MAX_DELAY))) begin
      cnt_d = cnt_q + DELAY_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q      <= '0;
      cnt_q        <= '0;
      prev_delay_q <= DELAY_W'(1);
      clamped_q    <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      prev_delay_q <= eff_delay;
      clamped_q    <= clamped_q | clamped_now;
    end
  end

  assign out_valid_o   = tap[VBit];
  assign out_data_o    = tap[WIDTH-1:0];
  // The tap still holds pre-change samples until the change edge is taken.
  assign primed_o      = !delay_changed && (cnt_q >= eff_delay);
  assign sel_clamped_o = clamped_q;

endmodule

// File: tb/tb_delay_line_var.sv
// Directed bench for delay_line_var: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_delay_line_var;

  logic       clk;
  logic       rst_ni;
  logic       en;
  logic       flush;
  logic [4:0] delay_sel;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       primed;
  logic       sel_clamped;

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] d;
    logic       p;
    logic       c;
    bit         dm;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  delay_line_var dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en_i          (en),
    .flush_i       (flush),
    .delay_sel_i   (delay_sel),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .primed_o      (primed),
    .sel_clamped_o (sel_clamped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare the oldest expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if ((out_valid !== e.v) || (primed !== e.p) || (sel_clamped !== e.c) ||
          (e.dm && (out_data !== e.d))) begin
        failures = failures + 1;
        $display("FAIL %s: got v=%0b d=%02h p=%0b c=%0b, want v=%0b d=%02h p=%0b c=%0b",
                 e.name, out_valid, out_data, primed, sel_clamped, e.v, e.d, e.p, e.c);
      end
    end
  end

  // Called at posedge+1: apply inputs, queue the expectation for this cycle.
  task automatic drive(input string ph, input int c, input logic e, input logic f,
                       input logic [4:0] sel, input logic v, input logic [7:0] d,
                       input logic xv, input logic [7:0] xd, input logic xp,
                       input logic xc);
    exp_t x;
    en        = e;
    flush     = f;
    delay_sel = sel;
    in_valid  = v;
    in_data   = d;
    x.name = $sformatf("%s[%0d]", ph, c);
    x.v = xv;
    x.d = xd;
    x.p = xp;
    x.c = xc;
    x.dm = 1'b1;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // One cycle in reset (outputs must clear at once), then one idle cycle.
  task automatic do_reset(input logic [4:0] sel);
    rst_ni = 1'b0;
    drive("reset", 0, 1'b0, 1'b0, sel, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_ni = 1'b1;
    drive("idle", 0, 1'b0, 1'b0, sel, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int eb[14];
    int ee;
    logic [7:0] di;
    logic       vi;
    checks    = 0;
    failures  = 0;
    rst_ni    = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    delay_sel = 5'd4;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;

    // Fixed latency D=4.
    do_reset(5'd4);
    for (int c = 0; c < 8; c++) begin
      drive("lat", c, 1'b1, 1'b0, 5'd4, 1'b1, 8'(c + 1),
            c >= 4, (c >= 4) ? 8'(c - 3) : 8'h00, c >= 4, 1'b0);
    end

    // Reset asserted mid-stream (pipeline full of valid words), then D=3 stall.
    in_valid = 1'b1;
    do_reset(5'd3);
    eb = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 9, 10, 11};
    for (int c = 0; c < 14; c++) begin
      if (c < 4) begin
        di = 8'(8'hA0 + c); vi = 1'b1;
      end else if (c < 6) begin
        di = 8'hA4; vi = 1'b1;
      end else if (c < 10) begin
        di = 8'(8'hA0 + c - 2); vi = 1'b1;
      end else begin
        di = 8'h00; vi = 1'b0;
      end
      ee = eb[c];
      if (ee < 3) begin
        drive("stall", c, !(c == 4 || c == 5), 1'b0, 5'd3, vi, di, 1'b0, 8'h00, 1'b0, 1'b0);
      end else if (ee - 3 <= 7) begin
        drive("stall", c, !(c == 4 || c == 5), 1'b0, 5'd3, vi, di,
              1'b1, 8'(8'hA0 + ee - 3), 1'b1, 1'b0);
      end else begin
        drive("stall", c, !(c == 4 || c == 5), 1'b0, 5'd3, vi, di, 1'b0, 8'h00, 1'b1, 1'b0);
      end
    end

    // Flush with D=5: data keeps shifting, valids and priming restart.
    do_reset(5'd5);
    for (int c = 0; c < 16; c++) begin
      drive("flush", c, 1'b1, c == 8, 5'd5, 1'b1, 8'(8'h10 + c),
            (c >= 5 && c <= 8) || c >= 14, (c >= 5) ? 8'(8'h10 + c - 5) : 8'h00,
            (c >= 5 && c <= 8) || c >= 14, 1'b0);
    end

    // Flush while stalled: valids drop, data holds.
    do_reset(5'd2);
    drive("flush_stall", 0, 1'b1, 1'b0, 5'd2, 1'b1, 8'h70, 1'b0, 8'h00, 1'b0, 1'b0);
    drive("flush_stall", 1, 1'b1, 1'b0, 5'd2, 1'b1, 8'h71, 1'b0, 8'h00, 1'b0, 1'b0);
    drive("flush_stall", 2, 1'b1, 1'b0, 5'd2, 1'b1, 8'h72, 1'b1, 8'h70, 1'b1, 1'b0);
    drive("flush_stall", 3, 1'b0, 1'b1, 5'd2, 1'b1, 8'h73, 1'b1, 8'h71, 1'b1, 1'b0);
    drive("flush_stall", 4, 1'b1, 1'b0, 5'd2, 1'b1, 8'h74, 1'b0, 8'h71, 1'b0, 1'b0);
    drive("flush_stall", 5, 1'b1, 1'b0, 5'd2, 1'b1, 8'h75, 1'b0, 8'h72, 1'b0, 1'b0);
    drive("flush_stall", 6, 1'b1, 1'b0, 5'd2, 1'b1, 8'h76, 1'b1, 8'h74, 1'b1, 1'b0);

    // Delay change 4 -> 2 -> 0 (clamped to 1) -> 19 (clamped to 16).
    do_reset(5'd4);
    for (int c = 0; c < 4; c++) begin
      drive("chg", c, 1'b1, 1'b0, 5'd4, 1'b1, 8'(8'h30 + c), 1'b0, 8'h00, 1'b0, 1'b0);
    end
    drive("chg", 4, 1'b1, 1'b0, 5'd4, 1'b1, 8'h34, 1'b1, 8'h30, 1'b1, 1'b0);
    drive("chg", 5, 1'b1, 1'b0, 5'd4, 1'b1, 8'h35, 1'b1, 8'h31, 1'b1, 1'b0);
    drive("chg", 6, 1'b1, 1'b0, 5'd2, 1'b1, 8'h36, 1'b1, 8'h34, 1'b0, 1'b0);
    drive("chg", 7, 1'b1, 1'b0, 5'd2, 1'b1, 8'h37, 1'b1, 8'h35, 1'b0, 1'b0);
    drive("chg", 8, 1'b1, 1'b0, 5'd2, 1'b1, 8'h38, 1'b1, 8'h36, 1'b1, 1'b0);
    drive("chg", 9, 1'b1, 1'b0, 5'd0, 1'b1, 8'h39, 1'b1, 8'h38, 1'b0, 1'b0);
    drive("chg", 10, 1'b1, 1'b0, 5'd0, 1'b1, 8'h3A, 1'b1, 8'h39, 1'b1, 1'b1);
    drive("chg", 11, 1'b1, 1'b0, 5'd0, 1'b1, 8'h3B, 1'b1, 8'h3A, 1'b1, 1'b1);
    for (int c = 12; c < 16; c++) begin
      drive("chg", c, 1'b1, 1'b0, 5'd19, 1'b1, 8'(8'h30 + c), 1'b0, 8'h00, 1'b0, 1'b1);
    end
    drive("chg", 16, 1'b1, 1'b0, 5'd19, 1'b1, 8'h40, 1'b1, 8'h30, 1'b0, 1'b1);
    drive("chg", 17, 1'b1, 1'b0, 5'd19, 1'b1, 8'h41, 1'b1, 8'h31, 1'b0, 1'b1);

    // Max depth: single pulse through all 16 stages; reset also clears the sticky flag.
    do_reset(5'd16);
    for (int c = 0; c < 19; c++) begin
      drive("max", c, 1'b1, 1'b0, 5'd16, c == 0, (c == 0) ? 8'h5A : 8'h00,
            c == 16, (c == 16) ? 8'h5A : 8'h00, c >= 16, 1'b0);
    end

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Parametrised successor to the single-bit fixed delay.
- Delays a WIDTH-bit data word plus a valid flag by a runtime-selectable number of enabled clock cycles (1..MAX_DELAY).
- Adds stall, flush and a "primed" indicator.
- Used to align video/sensor data paths with pipelined processing whose latency changes with mode.

Parameters:
- WIDTH, 8: data word width in bits (≥1).
- MAX_DELAY, 16: deepest supported delay in stages (≥2).
- DELAY_W, $clog2(MAX_DELAY+1): width of delay_sel; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  shift enable; low = stall, all state held.
- flush  in  1  synchronous clear of valid bits and priming counter.
- delay_sel  in  DELAY_W  requested delay in enabled cycles.
- in_data  in  WIDTH  input word.
- in_valid  in  1  input word qualifier.
- out_data  out  WIDTH  word from the selected tap.
- out_valid  out  1  valid flag from the selected tap.
- primed  out  1  high once the selected tap holds only post-flush/post-change samples.
- sel_clamped  out  1  sticky flag: delay_sel was out of range at least once.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All data stages cleared to 0 and all valid stages to 0.
  - Priming counter 0, sel_clamped 0.
  - Outputs during and after reset: out_data=0, out_valid=0, primed=0, sel_clamped=0.
- Effective delay D:
  - D = delay_sel, clamped to 1 when delay_sel=0 and to MAX_DELAY when delay_sel>MAX_DELAY.
  - sel_clamped sets on any clock edge where clamping applied (regardless of en) and clears only on reset.
- Storage:
  - MAX_DELAY stages of {valid, data}.
  - On an edge with en=1: stage0 <= {in_valid,in_data}; stage k <= stage k-1.
  - On an edge with en=0: all stages hold, including when flush=0.
- Output:
  - {out_valid,out_data} = stage[D-1], a combinational mux from registers with no extra register.
  - Latency is exactly D enabled edges: a word sampled on enabled edge n appears after enabled edge n+D-1.
  - Stalled edges do not count toward latency.
- Flush (synchronous, overrides en):
  - All valid stages <= 0; data stages keep shifting if en=1, otherwise hold.
  - Priming counter <= 0.
  - The sample presented on a flush edge is discarded: its valid is forced to 0.
- Priming counter:
  - Saturating, DELAY_W bits; increments on each enabled, non-flush edge up to MAX_DELAY.
  - primed = (count ≥ D).
  - Reset to 0 on the edge after delay_sel's effective value changes. A change is detected by registering the previous effective D, which resets to 1.
- Delay change mid-stream:
  - out_* switches tap immediately (combinational).
  - primed drops for D enabled cycles.
  - Data and valid are not flushed automatically; consumers gate on primed.
- Simultaneous events:
  - flush with delay change: counter 0.
  - flush with en=0: valids cleared, data held.
  - in_valid is ignored when flush=1.
- X-safety: delay_sel outside range never indexes beyond MAX_DELAY-1.

Decomposition:
- Shared package delay_pkg: function clog2, default WIDTH/MAX_DELAY constants, and the valid+data stage record layout (valid at MSB).
- One natural sub-module, delay_tap_mux: parametrised MAX_DELAY-way combinational selector of {valid,data}, including the clamp logic and the clamped flag.
- Shift stages and counter live in delay_line_var.
- Target size 150-250 lines.

Test Plan:
- Reset: hold rst_n=0 mid-stream with in_valid=1 -> out_data=0, out_valid=0, primed=0 immediately (asynchronous), all zero on first edge after release.
- Fixed latency: D=4, en=1, in_data=1,2,3,… with in_valid=1 -> out_data=1 visible after 4th edge; primed rises same cycle; out_valid=1 thereafter.
- Stall: D=3, stream 0xA0..0xA7, en low for 2 cycles mid-stream -> output frozen for exactly those cycles, no word dropped or duplicated, order preserved.
- Flush: D=5 streaming valid data, flush=1 one cycle -> out_valid=0 for next 5 enabled edges, primed=0 for 5 edges, then out_valid/primed return 1.
- Delay change and clamp: switch delay_sel 4->2 -> output immediately shows stage[1], primed low 2 enabled edges. Then delay_sel=0 -> behaves as D=1, sel_clamped=1 and stays 1. Then delay_sel=MAX_DELAY+3 -> behaves as D=MAX_DELAY.
- Max depth: D=MAX_DELAY=16, single valid pulse 0x5A -> appears exactly after 16th enabled edge, out_valid high one cycle.
